// File: rtl/usb_reg_bridge.sv
// usb_reg_bridge
//   Bridges an asynchronous-style external parallel bus (chip enable plus
//   active-low read/write strobes) onto single-cycle register-block strobes.
//   All inputs are registered once (S1). The strobes are registered a second
//   time (S2) so that falling edges can be detected. A small FSM turns each
//   accepted edge into one reg_write or reg_read pulse. For reads, it then
//   drives the captured byte back onto the bus while the read strobe stays low.
//
// Ports
//   usb_clk        sole clock, rising edge
//   reset_i        asynchronous, active-high reset
//   usb_addr       external address; upper bits -> reg_address, low bits -> reg_bytecnt
//   usb_din        external write data
//   usb_cen_n      chip enable, active-low
//   usb_rdn        read strobe, active-low
//   usb_wrn        write strobe, active-low
//   usb_dout       registered read data to the external bus
//   usb_isout      external data-bus drive enable
//   reg_address    latched register address
//   reg_bytecnt    latched byte count
//   write_data     latched write byte
//   read_data      register-block read data, valid the cycle after reg_read
//   reg_read       one-cycle read strobe
//   reg_write      one-cycle write strobe
//   reg_addrvalid  registered chip-enable qualifier
//   O_collision    sticky flag: read and write strobes seen low together
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a read or write strobe falling edge
// WRITE   | write accepted, waiting for the write strobe to release
// RD_REQ  | reg_read asserted to the register block
// RD_CAP  | read_data valid, captured into usb_dout at the end of the cycle
// RD_HOLD | driving usb_dout on the bus until the read strobe releases

module usb_reg_bridge #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_i,
    input  logic [pADDR_WIDTH-1:0]                 usb_addr,
    input  logic [7:0]                             usb_din,
    input  logic                                   usb_cen_n,
    input  logic                                   usb_rdn,
    input  logic                                   usb_wrn,
    output logic [7:0]                             usb_dout,
    output logic                                   usb_isout,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             write_data,
    input  logic [7:0]                             read_data,
    output logic                                   reg_read,
    output logic                                   reg_write,
    output logic                                   reg_addrvalid,
    output logic                                   O_collision
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_CAP  = 3'd3,
        RD_HOLD = 3'd4
    } state_t;

    state_t state, state_next;

    logic [pADDR_WIDTH-1:0] addr_s1;
    logic [7:0]             din_s1;
    logic                   cen_n_s1;
    logic                   rdn_s1;
    logic                   wrn_s1;
    logic                   rdn_s2;
    logic                   wrn_s2;

    // The strobe pipeline resets to "inactive". If a strobe is already low
    // when reset releases, that would look like a falling edge. An edge is
    // therefore only honoured once the strobe has actually been sampled high
    // after reset. The first S1 sample after release still holds reset values,
    // so sample_ok keeps it from arming anything.
    logic sample_ok;
    logic wr_armed;
    logic rd_armed;

    logic wr_edge;
    logic rd_edge;
    logic wr_start;
    logic rd_start;
    logic collide;
    logic isout_next;
    logic load_dout;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            addr_s1  <= '0;
            din_s1   <= '0;
            cen_n_s1 <= 1'b1;
            rdn_s1   <= 1'b1;
            wrn_s1   <= 1'b1;
            rdn_s2   <= 1'b1;
            wrn_s2   <= 1'b1;
        end else begin
            addr_s1  <= usb_addr;
            din_s1   <= usb_din;
            cen_n_s1 <= usb_cen_n;
            rdn_s1   <= usb_rdn;
            wrn_s1   <= usb_wrn;
            rdn_s2   <= rdn_s1;
            wrn_s2   <= wrn_s1;
        end
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            sample_ok <= 1'b0;
            wr_armed  <= 1'b0;
            rd_armed  <= 1'b0;
        end else begin
            sample_ok <= 1'b1;
            if (sample_ok && wrn_s1) wr_armed <= 1'b1;
            if (sample_ok && rdn_s1) rd_armed <= 1'b1;
        end
    end

    assign wr_edge = wr_armed && !wrn_s1 && wrn_s2;
    assign rd_edge = rd_armed && !rdn_s1 && rdn_s2;

    // State register
    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (state != IDLE && cen_n_s1) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!cen_n_s1 && !(!rdn_s1 && !wrn_s1)) begin
                        if (wr_edge && rdn_s1)      state_next = WRITE;
                        else if (rd_edge && wrn_s1) state_next = RD_REQ;
                    end
                end
                WRITE:   if (wrn_s1) state_next = IDLE;
                RD_REQ:  state_next = RD_CAP;
                RD_CAP:  state_next = rdn_s1 ? IDLE : RD_HOLD;
                RD_HOLD: if (rdn_s1) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode; the results are registered below.
    always_comb begin
        wr_start   = (state == IDLE) && (state_next == WRITE);
        rd_start   = (state == IDLE) && (state_next == RD_REQ);
        collide    = (state == IDLE) && !cen_n_s1 && !rdn_s1 && !wrn_s1;
        isout_next = (state_next == RD_HOLD);
        load_dout  = (state == RD_CAP);
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            write_data    <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
            O_collision   <= 1'b0;
        end else begin
            reg_addrvalid <= ~cen_n_s1;
            reg_write     <= wr_start;
            reg_read      <= rd_start;
            usb_isout     <= isout_next;
            if (wr_start || rd_start) begin
                reg_address <= addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
                reg_bytecnt <= addr_s1[pBYTECNT_SIZE-1:0];
            end
            if (wr_start)  write_data  <= din_s1;
            if (load_dout) usb_dout    <= read_data;
            if (collide)   O_collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_reg_bridge.sv
module tb_usb_reg_bridge;

    logic        usb_clk = 1'b0;
    logic        reset_i;
    logic [20:0] usb_addr;
    logic [7:0]  usb_din;
    logic        usb_cen_n;
    logic        usb_rdn;
    logic        usb_wrn;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic        O_collision;

    usb_reg_bridge #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) dut (
        .usb_clk       (usb_clk),
        .reset_i       (reset_i),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_cen_n     (usb_cen_n),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .write_data    (write_data),
        .read_data     (read_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .O_collision   (O_collision)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        bit          is_write;
        logic [13:0] addr;
        logic [6:0]  cnt;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] rd_value = 8'h00;

    // Register block: read_data is valid only in the cycle after reg_read.
    always @(posedge usb_clk) read_data <= reg_read ? rd_value : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input bit w, input logic [20:0] a, input logic [7:0] d);
        exp_t e;
        e.is_write = w;
        e.addr     = a[20:7];
        e.cnt      = a[6:0];
        e.data     = d;
        return e;
    endfunction

    // Scoreboard monitor: every strobe pulse must match the oldest expectation.
    always @(negedge usb_clk) begin
        if (reg_write || reg_read) begin
            chk("sb_pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind_write", {31'd0, reg_write}, {31'd0, e.is_write});
                chk("sb_kind_read", {31'd0, reg_read}, {31'd0, !e.is_write});
                chk("sb_reg_address", {18'd0, reg_address}, {18'd0, e.addr});
                chk("sb_reg_bytecnt", {25'd0, reg_bytecnt}, {25'd0, e.cnt});
                if (e.is_write) chk("sb_write_data", {24'd0, write_data}, {24'd0, e.data});
            end
        end
    end

    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int ncyc);
        sb.push_back(mk(1'b1, a, d));
        @(negedge usb_clk);
        usb_cen_n = 1'b0;
        usb_addr  = a;
        usb_din   = d;
        usb_wrn   = 1'b0;
        repeat (ncyc) @(negedge usb_clk);
        usb_wrn = 1'b1;
        repeat (3) @(negedge usb_clk);
        chk("wr_reg_write_idle", {31'd0, reg_write}, 32'd0);
        chk("wr_write_data", {24'd0, write_data}, {24'd0, d});
    endtask

    task automatic do_read(input logic [20:0] a, input logic [7:0] d, input int ncyc);
        int hi;
        hi = 0;
        rd_value = d;
        sb.push_back(mk(1'b0, a, 8'h00));
        @(negedge usb_clk);
        usb_cen_n = 1'b0;
        usb_addr  = a;
        usb_rdn   = 1'b0;
        for (int i = 1; i <= ncyc + 8; i++) begin
            @(negedge usb_clk);
            if (usb_isout) hi++;
            if (i == ncyc) usb_rdn = 1'b1;
        end
        // Bus is driven from the 4th edge after the strobe falls until the
        // edge after the released strobe reaches S1.
        chk("rd_isout_cycles", hi, (ncyc > 2) ? ncyc - 2 : 0);
        chk("rd_dout", {24'd0, usb_dout}, {24'd0, d});
        chk("rd_isout_low_after", {31'd0, usb_isout}, 32'd0);
    endtask

    initial begin
        reset_i   = 1'b1;
        usb_addr  = '0;
        usb_din   = '0;
        usb_cen_n = 1'b1;
        usb_rdn   = 1'b1;
        usb_wrn   = 1'b1;
        repeat (3) @(negedge usb_clk);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_reg_read", {31'd0, reg_read}, 32'd0);
        chk("rst_isout", {31'd0, usb_isout}, 32'd0);
        chk("rst_dout", {24'd0, usb_dout}, 32'd0);
        chk("rst_collision", {31'd0, O_collision}, 32'd0);
        chk("rst_addrvalid", {31'd0, reg_addrvalid}, 32'd0);
        chk("rst_reg_address", {18'd0, reg_address}, 32'd0);
        reset_i = 1'b0;
        repeat (3) @(negedge usb_clk);

        // Basic write, 3-cycle strobe
        do_write(21'h00283, 8'hA5, 3);
        chk("wr1_reg_address", {18'd0, reg_address}, 32'h5);
        chk("wr1_reg_bytecnt", {25'd0, reg_bytecnt}, 32'h3);
        chk("addrvalid_cen_low", {31'd0, reg_addrvalid}, 32'd1);

        // Latched fields stay put while the bus changes without a strobe
        usb_addr = 21'h1ABCDE;
        usb_din  = 8'h3F;
        repeat (4) @(negedge usb_clk);
        chk("hold_reg_address", {18'd0, reg_address}, 32'h5);
        chk("hold_write_data", {24'd0, write_data}, 32'hA5);

        // Single-cycle write at the top of the address space
        do_write(21'h1FFFFF, 8'h5A, 1);
        chk("wr2_reg_address", {18'd0, reg_address}, 32'h3FFF);
        chk("wr2_reg_bytecnt", {25'd0, reg_bytecnt}, 32'h7F);

        // Reads: long, single-cycle, shortest that reaches RD_HOLD
        do_read(21'h00283, 8'h3C, 6);
        do_read(21'h01234, 8'h96, 1);
        do_read(21'h00555, 8'h0F, 3);

        // Collision: both strobes fall together
        @(negedge usb_clk);
        usb_rdn = 1'b0;
        usb_wrn = 1'b0;
        repeat (3) @(negedge usb_clk);
        usb_rdn = 1'b1;
        usb_wrn = 1'b1;
        repeat (3) @(negedge usb_clk);
        chk("coll_flag_set", {31'd0, O_collision}, 32'd1);
        do_write(21'h00081, 8'hC7, 2);
        chk("coll_flag_sticky", {31'd0, O_collision}, 32'd1);

        // Abort: chip enable rises while the read data is on the bus
        rd_value = 8'h77;
        sb.push_back(mk(1'b0, 21'h00400, 8'h00));
        @(negedge usb_clk);
        usb_addr = 21'h00400;
        usb_rdn  = 1'b0;
        repeat (5) @(negedge usb_clk);
        chk("abort_isout_before", {31'd0, usb_isout}, 32'd1);
        usb_cen_n = 1'b1;
        @(negedge usb_clk);
        chk("abort_isout_cen_in_s1", {31'd0, usb_isout}, 32'd1);
        @(negedge usb_clk);
        chk("abort_isout_cleared", {31'd0, usb_isout}, 32'd0);
        chk("abort_dout", {24'd0, usb_dout}, 32'h77);
        usb_rdn = 1'b1;
        repeat (2) @(negedge usb_clk);
        do_read(21'h0ABCD, 8'hC3, 4);

        // Reset in the middle of a write, released with the strobe still low
        sb.push_back(mk(1'b1, 21'h00101, 8'h11));
        @(negedge usb_clk);
        usb_cen_n = 1'b0;
        usb_addr  = 21'h00101;
        usb_din   = 8'h11;
        usb_wrn   = 1'b0;
        repeat (4) @(negedge usb_clk);
        chk("rstw_write_data_pre", {24'd0, write_data}, 32'h11);
        reset_i = 1'b1;
        repeat (2) @(negedge usb_clk);
        chk("rstw_write_data_rst", {24'd0, write_data}, 32'd0);
        chk("rstw_collision_rst", {31'd0, O_collision}, 32'd0);
        reset_i = 1'b0;
        usb_din = 8'h22;
        repeat (6) @(negedge usb_clk);
        chk("rstw_no_write", {24'd0, write_data}, 32'd0);
        usb_wrn = 1'b1;
        repeat (3) @(negedge usb_clk);
        sb.push_back(mk(1'b1, 21'h00101, 8'h22));
        usb_wrn = 1'b0;
        repeat (3) @(negedge usb_clk);
        usb_wrn = 1'b1;
        repeat (3) @(negedge usb_clk);
        chk("rstw_new_write", {24'd0, write_data}, 32'h22);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
